bvh_traversal_ctrl: RTL and testbench

Traversal controller sitting directly downstream of the ray/AABB slab intersector in the BVH walk. It consumes the `tmin`/`tmax` results for a node's two children and decides which children the ray hits. It orders hit children near-to-far, holds deferred far children on an internal LIFO, and issues the next node index back to the intersector's fetch side. It also signals when the ray's traversal is exhausted.

---
 rtl/bvh_pkg.sv | 30 +++
 rtl/bvh_traversal_ctrl_if.sv | 46 ++++
 rtl/bvh_node_stack.sv | 58 +++++
 rtl/bvh_traversal_ctrl.sv | 151 +++++++++++++++
 tb/tb_bvh_traversal_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/bvh_pkg.sv
// ============================================================================
// bvh_pkg : shared types, constants and float-ordering helpers for the BVH walk
// Revision: 1.0
// ============================================================================
`default_nettype none

package bvh_pkg;

   localparam int c_IDX_W = 24;
   localparam int c_T_W   = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Maps an IEEE-754 single onto an unsigned total order (-0 sorts below +0)
   function automatic logic [31:0] float_key(input logic [31:0] f);
      return f[31] ? ~f : (f | 32'h8000_0000);
   endfunction

   function automatic logic is_nan(input logic [31:0] f);
      return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
   endfunction

endpackage

`default_nettype wire

// File: rtl/bvh_traversal_ctrl_if.sv
// ============================================================================
// bvh_traversal_ctrl_if : ray control, child-pair input and fetch-index output
// Revision: 1.0
// ============================================================================
`default_nettype none

interface bvh_traversal_ctrl_if
   import bvh_pkg::*;
#(
   parameter int IDX_W = c_IDX_W,
   parameter int T_W   = c_T_W,
   parameter int DEPTH = 32
);
   logic                         ray_start;
   logic [IDX_W-1:0]             root_idx;
   logic                         in_valid;
   logic                         in_ready;
   logic [IDX_W-1:0]             in_lo_idx;
   logic [IDX_W-1:0]             in_hi_idx;
   logic [T_W-1:0]               in_lo_tmin;
   logic [T_W-1:0]               in_lo_tmax;
   logic [T_W-1:0]               in_hi_tmin;
   logic [T_W-1:0]               in_hi_tmax;
   logic                         out_valid;
   logic                         out_ready;
   logic [IDX_W-1:0]             out_idx;
   logic                         done;
   logic                         busy;
   logic                         overflow;
   logic [$clog2(DEPTH+1)-1:0]   depth;

   modport slave (
      input  ray_start, root_idx, in_valid, in_lo_idx, in_hi_idx,
             in_lo_tmin, in_lo_tmax, in_hi_tmin, in_hi_tmax, out_ready,
      output in_ready, out_valid, out_idx, done, busy, overflow, depth
   );

   modport master (
      output ray_start, root_idx, in_valid, in_lo_idx, in_hi_idx,
             in_lo_tmin, in_lo_tmax, in_hi_tmin, in_hi_tmax, out_ready,
      input  in_ready, out_valid, out_idx, done, busy, overflow, depth
   );

endinterface

`default_nettype wire

// File: rtl/bvh_node_stack.sv
// ============================================================================
// bvh_node_stack : LIFO of deferred far-child indices, combinational top read
// Revision: 1.0
// ============================================================================
`default_nettype none

module bvh_node_stack #(
   parameter int DEPTH = 32,
   parameter int IDX_W = 24,
   parameter int CNT_W = $clog2(DEPTH+1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  logic [IDX_W-1:0] push_idx,
   output logic [IDX_W-1:0] top_idx,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [IDX_W-1:0] r_mem [DEPTH];
   logic [CNT_W-1:0] r_count;
   logic [AW-1:0]    w_wr_ptr;
   logic [AW-1:0]    w_top_ptr;

   assign full      = (r_count == CNT_W'(DEPTH));
   assign empty     = (r_count == '0);
   assign count     = r_count;
   assign w_wr_ptr  = r_count[AW-1:0];
   assign w_top_ptr = AW'(r_count - 1'b1);
   assign top_idx   = r_mem[w_top_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (push && !full) begin
         r_count <= r_count + 1'b1;
      end else if (pop && !empty) begin
         r_count <= r_count - 1'b1;
      end
   end

   // Storage needs no reset: entries are only read below the count
   always_ff @(posedge clk) begin
      if (!clear && push && !full) begin
         r_mem[w_wr_ptr] <= push_idx;
      end
   end

endmodule

`default_nettype wire

// File: rtl/bvh_traversal_ctrl.sv
// ============================================================================
// bvh_traversal_ctrl : orders hit children near-to-far, defers far children
// Revision: 1.0
// ============================================================================
`default_nettype none

module bvh_traversal_ctrl
   import bvh_pkg::*;
#(
   parameter int IDX_W = c_IDX_W,
   parameter int T_W   = c_T_W,
   parameter int DEPTH = 32
) (
   input  logic                clk,
   input  logic                reset,
   bvh_traversal_ctrl_if.slave bus
);
   localparam int CNT_W = $clog2(DEPTH+1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [IDX_W-1:0] r_out_idx;
   logic [IDX_W-1:0] w_idx_nxt;
   logic [IDX_W-1:0] w_near_idx;
   logic [IDX_W-1:0] w_far_idx;
   logic [IDX_W-1:0] w_top_idx;
   logic             r_overflow;
   logic             w_push;
   logic             w_pop;
   logic             w_full;
   logic             w_empty;
   logic [CNT_W-1:0] w_count;
   logic [T_W-1:0]   w_lo_tmin, w_lo_tmax, w_hi_tmin, w_hi_tmax;
   logic             w_hit_lo, w_hit_hi, w_lo_near;
   logic             w_in_ready, w_out_valid, w_done, w_busy;

   assign w_lo_tmin = bus.in_lo_tmin;
   assign w_lo_tmax = bus.in_lo_tmax;
   assign w_hi_tmin = bus.in_hi_tmin;
   assign w_hi_tmax = bus.in_hi_tmax;

   assign w_hit_lo  = !is_nan(w_lo_tmin) && !is_nan(w_lo_tmax) &&
                      (float_key(w_lo_tmin) <= float_key(w_lo_tmax));
   assign w_hit_hi  = !is_nan(w_hi_tmin) && !is_nan(w_hi_tmax) &&
                      (float_key(w_hi_tmin) <= float_key(w_hi_tmax));
   assign w_lo_near = float_key(w_lo_tmin) <= float_key(w_hi_tmin);
   assign w_near_idx = w_lo_near ? bus.in_lo_idx : bus.in_hi_idx;
   assign w_far_idx  = w_lo_near ? bus.in_hi_idx : bus.in_lo_idx;

   bvh_node_stack #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W),
      .CNT_W (CNT_W)
   ) u_stack (
      .clk      (clk),
      .reset    (reset),
      .clear    (bus.ray_start),
      .push     (w_push),
      .pop      (w_pop),
      .push_idx (w_far_idx),
      .top_idx  (w_top_idx),
      .full     (w_full),
      .empty    (w_empty),
      .count    (w_count)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ray_start overrides any handshake in flight; the stack clears on it too
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_out_idx;
      w_push      = 1'b0;
      w_pop       = 1'b0;
      if (bus.ray_start) begin
         w_state_nxt = ST_ISSUE;
         w_idx_nxt   = bus.root_idx;
      end else begin
         case (r_state)
            ST_ISSUE: if (bus.out_ready) w_state_nxt = ST_WAIT;
            ST_WAIT: begin
               if (bus.in_valid) begin
                  w_state_nxt = ST_ISSUE;
                  case ({w_hit_lo, w_hit_hi})
                     2'b11: begin
                        w_push    = 1'b1;
                        w_idx_nxt = w_near_idx;
                     end
                     2'b10: w_idx_nxt = bus.in_lo_idx;
                     2'b01: w_idx_nxt = bus.in_hi_idx;
                     default: begin
                        if (w_empty) begin
                           w_state_nxt = ST_DONE;
                        end else begin
                           w_pop     = 1'b1;
                           w_idx_nxt = w_top_idx;
                        end
                     end
                  endcase
               end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = r_state;
         endcase
      end
   end

   always_comb begin
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      w_done      = 1'b0;
      w_busy      = (r_state != ST_IDLE);
      case (r_state)
         ST_ISSUE: w_out_valid = 1'b1;
         ST_WAIT:  w_in_ready  = 1'b1;
         ST_DONE:  w_done      = 1'b1;
         default:  w_busy      = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_idx  <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_out_idx <= w_idx_nxt;
         if (bus.ray_start) begin
            r_overflow <= 1'b0;
         end else if (w_push && w_full) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.done      = w_done;
   assign bus.busy      = w_busy;
   assign bus.out_idx   = r_out_idx;
   assign bus.overflow  = r_overflow;
   assign bus.depth     = w_count;

endmodule

`default_nettype wire

// File: tb/tb_bvh_traversal_ctrl.sv
// ============================================================================
// tb_bvh_traversal_ctrl : directed bench; DUT a has DEPTH=8, DUT b has DEPTH=2
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bvh_traversal_ctrl;
   localparam logic [31:0] F_0P0 = 32'h0000_0000;
   localparam logic [31:0] F_N0P0 = 32'h8000_0000;
   localparam logic [31:0] F_1P0 = 32'h3F80_0000;
   localparam logic [31:0] F_1P5 = 32'h3FC0_0000;
   localparam logic [31:0] F_2P0 = 32'h4000_0000;
   localparam logic [31:0] F_3P0 = 32'h4040_0000;
   localparam logic [31:0] F_4P0 = 32'h4080_0000;
   localparam logic [31:0] F_5P0 = 32'h40A0_0000;
   localparam logic [31:0] F_NAN = 32'h7FC0_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ray_start = 1'b0;
   logic [23:0] root_idx = '0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [23:0] lo_idx = '0, hi_idx = '0;
   logic [31:0] lo_tmin = '0, lo_tmax = '0, hi_tmin = '0, hi_tmax = '0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   bvh_traversal_ctrl_if #(.IDX_W(24), .T_W(32), .DEPTH(8)) ifa ();
   bvh_traversal_ctrl_if #(.IDX_W(24), .T_W(32), .DEPTH(2)) ifb ();

   assign ifa.ray_start = ray_start;  assign ifb.ray_start = ray_start;
   assign ifa.root_idx = root_idx;    assign ifb.root_idx = root_idx;
   assign ifa.in_valid = in_valid;    assign ifb.in_valid = in_valid;
   assign ifa.out_ready = out_ready;  assign ifb.out_ready = out_ready;
   assign ifa.in_lo_idx = lo_idx;     assign ifb.in_lo_idx = lo_idx;
   assign ifa.in_hi_idx = hi_idx;     assign ifb.in_hi_idx = hi_idx;
   assign ifa.in_lo_tmin = lo_tmin;   assign ifb.in_lo_tmin = lo_tmin;
   assign ifa.in_lo_tmax = lo_tmax;   assign ifb.in_lo_tmax = lo_tmax;
   assign ifa.in_hi_tmin = hi_tmin;   assign ifb.in_hi_tmin = hi_tmin;
   assign ifa.in_hi_tmax = hi_tmax;   assign ifb.in_hi_tmax = hi_tmax;

   bvh_traversal_ctrl #(.IDX_W(24), .T_W(32), .DEPTH(8)) dut_a (
      .clk (clk), .reset (reset), .bus (ifa.slave)
   );
   bvh_traversal_ctrl #(.IDX_W(24), .T_W(32), .DEPTH(2)) dut_b (
      .clk (clk), .reset (reset), .bus (ifb.slave)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start(input logic [23:0] root);
      ray_start = 1'b1;
      root_idx  = root;
      tick();
      ray_start = 1'b0;
   endtask

   task automatic take;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic pair(input logic [23:0] li, input logic [31:0] lmin, input logic [31:0] lmax,
                       input logic [23:0] hi, input logic [31:0] hmin, input logic [31:0] hmax);
      lo_idx = li; lo_tmin = lmin; lo_tmax = lmax;
      hi_idx = hi; hi_tmin = hmin; hi_tmax = hmax;
   endtask

   task automatic result(input logic [23:0] li, input logic [31:0] lmin, input logic [31:0] lmax,
                         input logic [23:0] hi, input logic [31:0] hmin, input logic [31:0] hmax);
      pair(li, lmin, lmax, hi, hmin, hmax);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      // Reset state
      tick(); tick();
      chk("rst_out_valid", 32'(ifa.out_valid), 32'd0);
      chk("rst_in_ready",  32'(ifa.in_ready),  32'd0);
      chk("rst_done",      32'(ifa.done),      32'd0);
      chk("rst_busy",      32'(ifa.busy),      32'd0);
      chk("rst_overflow",  32'(ifa.overflow),  32'd0);
      chk("rst_out_idx",   32'(ifa.out_idx),   32'd0);
      chk("rst_depth",     32'(ifa.depth),     32'd0);
      reset = 1'b0;
      tick();

      // Both hit: hi nearer (tmin 1.0 < 2.0), lo deferred
      start(24'd100);
      chk("start_out_valid", 32'(ifa.out_valid), 32'd1);
      chk("start_out_idx",   32'(ifa.out_idx),   32'd100);
      chk("start_busy",      32'(ifa.busy),      32'd1);
      chk("start_in_ready",  32'(ifa.in_ready),  32'd0);
      take();
      chk("wait_in_ready",   32'(ifa.in_ready),  32'd1);
      chk("wait_out_valid",  32'(ifa.out_valid), 32'd0);
      result(24'd10, F_2P0, F_5P0, 24'd11, F_1P0, F_3P0);
      chk("both_out_valid",  32'(ifa.out_valid), 32'd1);
      chk("both_out_idx",    32'(ifa.out_idx),   32'd11);
      chk("both_depth",      32'(ifa.depth),     32'd1);
      take();
      result(24'd12, F_4P0, F_3P0, 24'd13, F_4P0, F_3P0);
      chk("pop_out_idx",     32'(ifa.out_idx),   32'd10);
      chk("pop_depth",       32'(ifa.depth),     32'd0);
      chk("pop_out_valid",   32'(ifa.out_valid), 32'd1);
      take();
      result(24'd12, F_4P0, F_3P0, 24'd13, F_4P0, F_3P0);
      chk("exh_done",        32'(ifa.done),      32'd1);
      chk("exh_out_valid",   32'(ifa.out_valid), 32'd0);
      chk("exh_busy",        32'(ifa.busy),      32'd1);
      tick();
      chk("idle_done",       32'(ifa.done),      32'd0);
      chk("idle_busy",       32'(ifa.busy),      32'd0);

      // Single hit, then NaN / signed-zero misses on an empty stack
      start(24'd200);
      take();
      result(24'd20, F_4P0, F_3P0, 24'd21, F_1P0, F_1P0);
      chk("single_out_idx",  32'(ifa.out_idx),   32'd21);
      chk("single_depth",    32'(ifa.depth),     32'd0);
      take();
      result(24'd22, F_NAN, F_5P0, 24'd23, F_0P0, F_N0P0);
      chk("nan_zero_done",   32'(ifa.done),      32'd1);
      chk("nan_zero_valid",  32'(ifa.out_valid), 32'd0);
      tick();

      // Tie on tmin: lo is near
      start(24'd300);
      take();
      result(24'd30, F_1P5, F_5P0, 24'd31, F_1P5, F_3P0);
      chk("tie_out_idx",     32'(ifa.out_idx),   32'd30);
      chk("tie_depth",       32'(ifa.depth),     32'd1);
      take();
      result(24'd32, F_4P0, F_3P0, 24'd33, F_4P0, F_3P0);
      chk("tie_pop_idx",     32'(ifa.out_idx),   32'd31);
      take();
      result(24'd32, F_4P0, F_3P0, 24'd33, F_4P0, F_3P0);
      chk("tie_done",        32'(ifa.done),      32'd1);
      tick();

      // Overflow on the DEPTH=2 instance; far children 41, 43, 45
      start(24'd400);
      for (int k = 0; k < 3; k++) begin
         take();
         result(24'(40 + 2*k), F_1P0, F_2P0, 24'(41 + 2*k), F_3P0, F_4P0);
         if (k < 2) chk("ovf_early_b", 32'(ifb.overflow), 32'd0);
      end
      chk("ovf_b_flag",      32'(ifb.overflow),  32'd1);
      chk("ovf_b_depth",     32'(ifb.depth),     32'd2);
      chk("ovf_b_out_idx",   32'(ifb.out_idx),   32'd44);
      chk("ovf_b_valid",     32'(ifb.out_valid), 32'd1);
      chk("ovf_a_depth",     32'(ifa.depth),     32'd3);
      chk("ovf_a_flag",      32'(ifa.overflow),  32'd0);
      take();
      result(24'd50, F_4P0, F_3P0, 24'd51, F_4P0, F_3P0);
      chk("ovf_pop1_idx",    32'(ifb.out_idx),   32'd43);
      chk("ovf_pop1_depth",  32'(ifb.depth),     32'd1);
      chk("ovf_a_pop1_idx",  32'(ifa.out_idx),   32'd45);
      take();
      result(24'd50, F_4P0, F_3P0, 24'd51, F_4P0, F_3P0);
      chk("ovf_pop2_idx",    32'(ifb.out_idx),   32'd41);
      chk("ovf_pop2_depth",  32'(ifb.depth),     32'd0);
      chk("ovf_sticky",      32'(ifb.overflow),  32'd1);
      take();
      result(24'd50, F_4P0, F_3P0, 24'd51, F_4P0, F_3P0);
      chk("ovf_b_done",      32'(ifb.done),      32'd1);

      // Abort in WAIT with depth 3, coincident with a valid result
      start(24'd500);
      for (int k = 0; k < 3; k++) begin
         take();
         result(24'(70 + 2*k), F_1P0, F_2P0, 24'(71 + 2*k), F_3P0, F_4P0);
      end
      take();
      chk("abort_pre_ready", 32'(ifa.in_ready),  32'd1);
      chk("abort_pre_depth", 32'(ifa.depth),     32'd3);
      pair(24'd80, F_1P0, F_2P0, 24'd81, F_3P0, F_4P0);
      in_valid  = 1'b1;
      ray_start = 1'b1;
      root_idx  = 24'd600;
      tick();
      in_valid  = 1'b0;
      ray_start = 1'b0;
      chk("abort_out_valid", 32'(ifa.out_valid), 32'd1);
      chk("abort_out_idx",   32'(ifa.out_idx),   32'd600);
      chk("abort_depth",     32'(ifa.depth),     32'd0);
      chk("abort_overflow",  32'(ifa.overflow),  32'd0);
      chk("abort_b_ovf",     32'(ifb.overflow),  32'd0);
      chk("abort_in_ready",  32'(ifa.in_ready),  32'd0);

      // Asynchronous reset mid-ray
      take();
      result(24'd60, F_1P0, F_2P0, 24'd61, F_3P0, F_4P0);
      chk("pre_rst_depth",   32'(ifa.depth),     32'd1);
      take();
      reset = 1'b1;
      #1;
      chk("mid_rst_in_ready", 32'(ifa.in_ready), 32'd0);
      chk("mid_rst_valid",    32'(ifa.out_valid), 32'd0);
      chk("mid_rst_busy",     32'(ifa.busy),     32'd0);
      chk("mid_rst_out_idx",  32'(ifa.out_idx),  32'd0);
      chk("mid_rst_depth",    32'(ifa.depth),    32'd0);
      chk("mid_rst_done",     32'(ifa.done),     32'd0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
